// File: rtl/regfile_32x32_if.sv
// regfile_32x32_if: read/write port bundle for the register file; master drives addresses and write data.
interface regfile_32x32_if #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 5
);
   logic [DEPTH_LOG2-1:0] Ra;
   logic [DEPTH_LOG2-1:0] Rb;
   logic [DEPTH_LOG2-1:0] Wr;
   logic                  We;
   logic [WIDTH-1:0]      D;
   logic [WIDTH-1:0]      Qa;
   logic [WIDTH-1:0]      Qb;
   modport master (output Ra, Rb, Wr, We, D, input Qa, Qb);
   modport slave  (input Ra, Rb, Wr, We, D, output Qa, Qb);
endinterface

// File: rtl/regfile_32x32.sv
// regfile_32x32: 2R/1W register file, r0 hardwired to zero; define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_32x32 #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic           Clk,
   input  logic           Clrn,
   regfile_32x32_if.slave bus
);
   localparam int N = 2**DEPTH_LOG2;
   logic [WIDTH-1:0] regs_q [N-1:1];
   logic [WIDTH-1:0] regs_d [N-1:1];
   logic             wr_en;
   logic [WIDTH-1:0] qa_st;
   logic [WIDTH-1:0] qb_st;
   assign wr_en = bus.We && (bus.Wr != '0);
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[bus.Wr] = bus.D;
   end
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end
   assign qa_st = (bus.Ra == '0) ? '0 : regs_q[bus.Ra];
   assign qb_st = (bus.Rb == '0) ? '0 : regs_q[bus.Rb];
`ifdef REGFILE_BYPASS_EN
   // wr_en excludes Wr==0, so a forwarded read can never hit r0
   assign bus.Qa = (Clrn && wr_en && bus.Ra == bus.Wr) ? bus.D : qa_st;
   assign bus.Qb = (Clrn && wr_en && bus.Rb == bus.Wr) ? bus.D : qb_st;
`else
   assign bus.Qa = qa_st;
   assign bus.Qb = qb_st;
`endif
endmodule

// File: tb/tb_regfile_32x32.sv
// tb_regfile_32x32: directed vectors with a per-cycle array model plus literal spot checks.
module tb_regfile_32x32;
   logic clk = 1'b0;
   logic clrn;
   logic run = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [31:0] model [32];

   regfile_32x32_if #(.WIDTH(32), .DEPTH_LOG2(5)) bus ();
   regfile_32x32 #(.WIDTH(32), .DEPTH_LOG2(5)) dut (.Clk(clk), .Clrn(clrn), .bus(bus.slave));

   always #5 clk = ~clk;

   initial foreach (model[i]) model[i] = '0;
   always @(negedge clrn) foreach (model[i]) model[i] = '0;
   always @(posedge clk) if (clrn === 1'b1 && bus.We && bus.Wr != 0) model[bus.Wr] = bus.D;

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (clrn && bus.We && bus.Wr == a) return bus.D;
`endif
      return model[a];
   endfunction

   always @(negedge clk) if (run) begin
      checks += 2;
      if (bus.Qa !== exp_rd(bus.Ra)) begin
         failures++;
         $display("FAIL model_qa t=%0t Ra=%0d got=%h exp=%h", $time, bus.Ra, bus.Qa, exp_rd(bus.Ra));
      end
      if (bus.Qb !== exp_rd(bus.Rb)) begin
         failures++;
         $display("FAIL model_qb t=%0t Rb=%0d got=%h exp=%h", $time, bus.Rb, bus.Qb, exp_rd(bus.Rb));
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drv(input logic [4:0] ra, input logic [4:0] rb, input logic we,
                      input logic [4:0] wr, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.Ra = ra; bus.Rb = rb; bus.We = we; bus.Wr = wr; bus.D = d;
   endtask

   initial begin
      clrn = 1'b0;
      bus.Ra = '0; bus.Rb = '0; bus.We = 1'b0; bus.Wr = '0; bus.D = '0;
      run = 1'b1;
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
      drv(5, 31, 0, 0, 0);
      #1 lit("reset_qa", bus.Qa, 32'h0);
      lit("reset_qb", bus.Qb, 32'h0);
      drv(5, 0, 1, 5, 32'h12345678);
      drv(5, 0, 0, 0, 0);
      #1 lit("preload_r5", bus.Qa, 32'h12345678);
      #2 clrn = 1'b0;
      #1 lit("clr_async", bus.Qa, 32'h0);
      bus.We = 1'b1; bus.Wr = 5; bus.D = 32'hCAFEF00D;
      @(posedge clk);
      #1 lit("clr_blocks_wr", bus.Qa, 32'h0);
      clrn = 1'b1; bus.We = 1'b0;
      drv(5, 5, 0, 0, 0);
      #1 lit("after_release", bus.Qb, 32'h0);
      drv(0, 0, 1, 0, 32'hFFFFFFFF);
      drv(0, 0, 0, 0, 0);
      #1 lit("r0_qa", bus.Qa, 32'h0);
      lit("r0_qb", bus.Qb, 32'h0);
      drv(0, 0, 1, 1, 32'hDEADBEEF);
      drv(0, 0, 1, 31, 32'h00000001);
      drv(1, 31, 0, 0, 0);
      #1 lit("basic_r1", bus.Qa, 32'hDEADBEEF);
      lit("basic_r31", bus.Qb, 32'h00000001);
      drv(1, 31, 0, 1, 32'h55555555);
      drv(1, 31, 0, 0, 0);
      #1 lit("we0_r1", bus.Qa, 32'hDEADBEEF);
      drv(0, 0, 1, 7, 32'h11111111);
      drv(7, 7, 1, 7, 32'h22222222);
`ifdef REGFILE_BYPASS_EN
      #1 lit("r7_pre_edge", bus.Qa, 32'h22222222);
`else
      #1 lit("r7_pre_edge", bus.Qa, 32'h11111111);
`endif
      drv(7, 0, 0, 0, 0);
      #1 lit("r7_post_edge", bus.Qa, 32'h22222222);
      drv(0, 0, 1, 9, 32'hA5A5A5A5);
      drv(9, 9, 0, 0, 0);
      #1 lit("dual_qa", bus.Qa, 32'hA5A5A5A5);
      lit("dual_qb", bus.Qb, 32'hA5A5A5A5);
      for (int i = 1; i < 32; i++) drv(0, 0, 1, 5'(i), 32'(i) * 32'h01010101);
      drv(0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         drv(5'(i), 5'(31 - i), 0, 0, 0);
         #1 lit($sformatf("sweep_qa_%0d", i), bus.Qa, 32'(i) * 32'h01010101);
         lit($sformatf("sweep_qb_%0d", 31 - i), bus.Qb, 32'(31 - i) * 32'h01010101);
      end
      @(posedge clk);
      #1 run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
